// File: rtl/mem_port_arbiter.sv
// Shares one single-port 16-bit memory between instruction fetch and the EXM data port.
// Wide data accesses take two word cycles, low word first; read data returns one cycle after issue.
module mem_port_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_gnt,
  output logic              o_f_valid,
  output logic [15:0]       o_f_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic              i_d_wide,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_valid,
  output logic [31:0]       o_d_rdata,
  output logic              o_stall_fetch,
  output logic              o_stall_data,
  output logic              o_m_en,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [15:0]       o_m_wdata,
  input  logic [15:0]       i_m_rdata
);

  // state   | meaning
  // IDLE    | arbitrate fetch vs data, issue one word
  // WIDE_HI | issue the high word of a latched 32-bit data access
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WIDE_HI = 1'b1;

  localparam logic [2:0] TAG_NONE     = 3'd0;
  localparam logic [2:0] TAG_FETCH    = 3'd1;
  localparam logic [2:0] TAG_D_NARROW = 3'd2;
  localparam logic [2:0] TAG_D_LO     = 3'd3;
  localparam logic [2:0] TAG_D_HI     = 3'd4;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [0:0]        state;
  logic [2:0]        tag;
  logic [SW-1:0]     streak;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [15:0]       lat_wdata;
  logic [15:0]       lo_word;
  logic [15:0]       f_hold;
  logic [31:0]       d_hold;

  logic run, sat, hi, f_win, d_win;

  // all combinational outputs are gated by run so they read low while reset is asserted
  assign run   = i_reset;
  assign sat   = (streak == SW'(STARVE_LIMIT));
  assign hi    = run & (state == WIDE_HI);
  assign f_win = run & (state == IDLE) & i_f_req & (~i_d_req | sat);
  assign d_win = run & (state == IDLE) & i_d_req & ~f_win;

  assign o_m_en        = f_win | d_win | hi;
  assign o_m_we        = (d_win & i_d_we) | (hi & lat_we);
  assign o_m_addr      = hi ? lat_addr : (f_win ? i_f_addr : i_d_addr);
  assign o_m_wdata     = hi ? lat_wdata : i_d_wdata[15:0];
  assign o_f_gnt       = f_win;
  assign o_d_gnt       = (d_win & ~i_d_wide) | hi;
  assign o_stall_fetch = run & i_f_req & ~o_f_gnt;
  assign o_stall_data  = run & i_d_req & ~o_d_gnt;

  assign o_f_valid = (tag == TAG_FETCH);
  assign o_d_valid = (tag == TAG_D_NARROW) | (tag == TAG_D_HI);
  assign o_f_rdata = (tag == TAG_FETCH) ? i_m_rdata : f_hold;

  always_comb begin
    o_d_rdata = d_hold;
    if (tag == TAG_D_NARROW) o_d_rdata = {16'h0000, i_m_rdata};
    else if (tag == TAG_D_HI) o_d_rdata = {i_m_rdata, lo_word};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      tag       <= TAG_NONE;
      streak    <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lo_word   <= '0;
      f_hold    <= '0;
      d_hold    <= '0;
    end else begin
      if (d_win && i_d_wide) begin
        state     <= WIDE_HI;
        lat_addr  <= i_d_addr + ADDR_W'(1);
        lat_we    <= i_d_we;
        lat_wdata <= i_d_wdata[31:16];
      end else if (hi) begin
        state <= IDLE;
      end

      if (f_win)                 tag <= TAG_FETCH;
      else if (d_win && !i_d_we) tag <= i_d_wide ? TAG_D_LO : TAG_D_NARROW;
      else if (hi && !lat_we)    tag <= TAG_D_HI;
      else                       tag <= TAG_NONE;

      if (!i_f_req || f_win)            streak <= '0;
      else if ((d_win || hi) && !sat)   streak <= streak + SW'(1);

      if (tag == TAG_FETCH) f_hold  <= i_m_rdata;
      if (tag == TAG_D_LO)  lo_word <= i_m_rdata;
      if (o_d_valid)        d_hold  <= o_d_rdata;
    end
  end

endmodule
